// File: rtl/miner_ctrl_if.sv
// Command/response channel between the nonce-search controller and a SHA-256
// compression core: one start pulse per block, one done pulse per result.
interface miner_ctrl_if;
  logic         cf_start;
  logic [511:0] cf_block;
  logic [255:0] cf_iv;
  logic         cf_done;
  logic [255:0] cf_digest;

  modport master (output cf_start, cf_block, cf_iv, input cf_done, cf_digest);
  modport slave  (input cf_start, cf_block, cf_iv, output cf_done, cf_digest);
endinterface

// File: rtl/miner_ctrl.sv
// Double-SHA-256 nonce search sequencer: computes the header midstate once,
// then runs two compression passes plus one compare cycle per nonce.
//
// state | meaning
// IDLE  | waiting for start; result flags held
// MID   | compressing hdr_head from the standard IV into the midstate
// PASS1 | compressing {hdr_tail, nonce, padding} from the midstate
// PASS2 | compressing first-pass digest from the standard IV
// CMP   | comparing second digest to target, advancing nonce
// DRAIN | aborted; waiting for the in-flight core result to discard it
module miner_ctrl (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [511:0]        hdr_head,
  input  logic [95:0]         hdr_tail,
  input  logic [31:0]         nonce_start,
  input  logic [31:0]         nonce_end,
  input  logic [255:0]        target,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [31:0]         nonce_out,
  output logic [255:0]        hash_out,
  miner_ctrl_if.master        cf
);

  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {IDLE, MID, PASS1, PASS2, CMP, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           found_q, found_d;
  logic           exhausted_q, exhausted_d;
  logic [31:0]    nonce_out_q, nonce_out_d;
  logic [255:0]   hash_out_q, hash_out_d;
  logic           cf_start_q, cf_start_d;
  logic [511:0]   cf_block_q, cf_block_d;
  logic [255:0]   cf_iv_q, cf_iv_d;
  logic [255:0]   midstate_q, midstate_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [31:0]    nonce_end_q, nonce_end_d;
  logic [255:0]   target_q, target_d;
  logic [95:0]    tail_q, tail_d;
  logic [255:0]   digest2_q, digest2_d;

  // Second header block: 16 data bytes, SHA padding, 80-byte message length.
  function automatic logic [511:0] pass1_block(input logic [95:0] tail, input logic [31:0] n);
    return {tail, n, 32'h8000_0000, 288'b0, 64'd640};
  endfunction

  function automatic logic [511:0] pass2_block(input logic [255:0] d1);
    return {d1, 32'h8000_0000, 160'b0, 64'd256};
  endfunction

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    nonce_out_d = nonce_out_q;
    hash_out_d  = hash_out_q;
    cf_start_d  = 1'b0;
    cf_block_d  = cf_block_q;
    cf_iv_d     = cf_iv_q;
    midstate_d  = midstate_q;
    nonce_d     = nonce_q;
    nonce_end_d = nonce_end_q;
    target_d    = target_q;
    tail_d      = tail_q;
    digest2_d   = digest2_q;

    // An abort that coincides with the core finishing has nothing left to drain.
    if ((state_q inside {MID, PASS1, PASS2}) && abort) begin
      if (cf.cf_done) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = DRAIN;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = MID;
            busy_d      = 1'b1;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            nonce_d     = nonce_start;
            nonce_end_d = nonce_end;
            target_d    = target;
            tail_d      = hdr_tail;
            cf_block_d  = hdr_head;
            cf_iv_d     = SHA_IV;
            cf_start_d  = 1'b1;
          end
        end
        MID: begin
          if (cf.cf_done) begin
            state_d    = PASS1;
            midstate_d = cf.cf_digest;
            cf_iv_d    = cf.cf_digest;
            cf_block_d = pass1_block(tail_q, nonce_q);
            cf_start_d = 1'b1;
          end
        end
        PASS1: begin
          if (cf.cf_done) begin
            state_d    = PASS2;
            cf_iv_d    = SHA_IV;
            cf_block_d = pass2_block(cf.cf_digest);
            cf_start_d = 1'b1;
          end
        end
        PASS2: begin
          if (cf.cf_done) begin
            state_d   = CMP;
            digest2_d = cf.cf_digest;
          end
        end
        CMP: begin
          if (abort) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
          end else if (digest2_q < target_q) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            found_d     = 1'b1;
            nonce_out_d = nonce_q;
            hash_out_d  = digest2_q;
          end else if (nonce_q == nonce_end_q) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            exhausted_d = 1'b1;
          end else begin
            state_d    = PASS1;
            nonce_d    = nonce_q + 32'd1;
            cf_iv_d    = midstate_q;
            cf_block_d = pass1_block(tail_q, nonce_q + 32'd1);
            cf_start_d = 1'b1;
          end
        end
        DRAIN: begin
          if (cf.cf_done) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      nonce_out_q <= '0;
      hash_out_q  <= '0;
      cf_start_q  <= 1'b0;
      cf_block_q  <= '0;
      cf_iv_q     <= '0;
      midstate_q  <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
      tail_q      <= '0;
      digest2_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      nonce_out_q <= nonce_out_d;
      hash_out_q  <= hash_out_d;
      cf_start_q  <= cf_start_d;
      cf_block_q  <= cf_block_d;
      cf_iv_q     <= cf_iv_d;
      midstate_q  <= midstate_d;
      nonce_q     <= nonce_d;
      nonce_end_q <= nonce_end_d;
      target_q    <= target_d;
      tail_q      <= tail_d;
      digest2_q   <= digest2_d;
    end
  end

  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign nonce_out   = nonce_out_q;
  assign hash_out    = hash_out_q;
  assign cf.cf_start = cf_start_q;
  assign cf.cf_block = cf_block_q;
  assign cf.cf_iv    = cf_iv_q;

endmodule

// File: tb/tb_miner_ctrl.sv
// Bench for miner_ctrl: behavioural SHA-256 core, reference double-hash search,
// and queues of expected PASS1 nonces and job results.
module tb_miner_ctrl;
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, abort;
  logic [511:0] hdr_head;
  logic [95:0]  hdr_tail;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic         busy, found, exhausted;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;

  miner_ctrl_if cf_if ();

  miner_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .hdr_head(hdr_head), .hdr_tail(hdr_tail), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .busy(busy), .found(found), .exhausted(exhausted),
    .nonce_out(nonce_out), .hash_out(hash_out), .cf(cf_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = iv;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + iv[255:224], b + iv[223:192], c + iv[191:160], d + iv[159:128],
            e + iv[127:96], f + iv[95:64], g + iv[63:32], h + iv[31:0]};
  endfunction

  function automatic logic [255:0] d2_of(input logic [511:0] head, input logic [95:0] tail, input logic [31:0] n);
    logic [255:0] mid, d1;
    mid = sha_comp(SHA_IV, head);
    d1  = sha_comp(mid, {tail, n, 32'h8000_0000, 288'b0, 64'd640});
    return sha_comp(SHA_IV, {d1, 32'h8000_0000, 160'b0, 64'd256});
  endfunction

  typedef struct {
    logic         found;
    logic         exh;
    logic [31:0]  nonce;
    logic [255:0] hash;
  } res_t;

  typedef struct {
    logic [511:0] head;
    logic [95:0]  tail;
    logic [31:0]  ns;
    logic [31:0]  ne;
    logic [255:0] tgt;
    bit           chk_const;
    logic         found;
    logic         exh;
    int           pulses;
  } vec_t;

  res_t         exp_rq[$];
  logic [31:0]  exp_nq[$];
  logic [31:0]  last_nonce = '0;
  logic [255:0] last_hash = '0;
  bit           sb_mute = 1'b0;

  // Behavioural compression core with programmable latency.
  int           core_lat = 3;
  int           model_kind = 0;
  bit           model_busy = 1'b0;
  logic [511:0] cap_blk;
  logic [255:0] cap_iv, dig;

  initial begin
    cf_if.cf_done   = 1'b0;
    cf_if.cf_digest = '0;
    forever begin
      @(negedge clk);
      cf_if.cf_done = 1'b0;
      if (cf_if.cf_start === 1'b1) begin
        cap_blk    = cf_if.cf_block;
        cap_iv     = cf_if.cf_iv;
        model_busy = 1'b1;
        model_kind = (cap_blk[63:0] == 64'd640) ? 1 : (cap_blk[63:0] == 64'd256) ? 2 : 0;
        dig        = sha_comp(cap_iv, cap_blk);
        repeat (core_lat) @(negedge clk);
        if (!sb_mute) check("cf_hold", {cf_if.cf_block == cap_blk, cf_if.cf_iv == cap_iv}, 2'b11);
        cf_if.cf_digest = dig;
        cf_if.cf_done   = 1'b1;
        model_busy      = 1'b0;
      end
    end
  end

  // Output monitor: cf_start pulse width, PASS1 nonce order, job results at busy fall.
  int   pulse_cnt = 0;
  logic prev_start = 1'b0, prev_busy = 1'b0, prev_found = 1'b0, prev_exh = 1'b0;
  res_t r_got;

  always @(negedge clk) begin
    if (cf_if.cf_start === 1'b1) begin
      pulse_cnt++;
      check("cf_start_one_cycle", prev_start, 1'b0);
      if (cf_if.cf_block[63:0] == 64'd640) begin
        if (exp_nq.size() == 0) fail_now("pass1_unexpected");
        else check("pass1_nonce", cf_if.cf_block[415:384], exp_nq.pop_front());
      end
    end
    if (prev_busy === 1'b1 && busy === 1'b0 && !sb_mute) begin
      if (exp_rq.size() == 0) fail_now("result_unexpected");
      else begin
        r_got = exp_rq.pop_front();
        check("found", found, r_got.found);
        check("exhausted", exhausted, r_got.exh);
        check("flags_with_busy_fall", {prev_found, prev_exh}, 2'b00);
        check("nonce_out", nonce_out, r_got.nonce);
        check("hash_out", hash_out, r_got.hash);
      end
    end
    prev_start = cf_if.cf_start;
    prev_busy  = busy;
    prev_found = found;
    prev_exh   = exhausted;
  end

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k >= 3000) fail_now(name);
  endtask

  task automatic wait_model_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!model_busy) break;
    end
    if (k >= 200) fail_now("core_model_idle");
  endtask

  task automatic drive_job(input vec_t v, input logic with_abort);
    @(negedge clk);
    hdr_head = v.head; hdr_tail = v.tail; nonce_start = v.ns; nonce_end = v.ne; target = v.tgt;
    start = 1'b1; abort = with_abort;
    pulse_cnt = 0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Reference search; pushes expected PASS1 nonces and the final result.
  task automatic run_job(input vec_t v, input bit extra_start, input logic with_abort);
    res_t         r;
    logic [31:0]  n;
    logic [255:0] d2;
    int           tried;
    n = v.ns; tried = 0;
    r.found = 1'b0; r.exh = 1'b0;
    forever begin
      tried++;
      exp_nq.push_back(n);
      d2 = d2_of(v.head, v.tail, n);
      if (d2 < v.tgt) begin r.found = 1'b1; last_nonce = n; last_hash = d2; break; end
      if (n == v.ne) begin r.exh = 1'b1; break; end
      if (tried >= 64) break;
      n = n + 32'd1;
    end
    r.nonce = last_nonce; r.hash = last_hash;
    exp_rq.push_back(r);
    drive_job(v, with_abort);
    if (extra_start) begin
      repeat (4) @(negedge clk);
      hdr_head = ~v.head; nonce_start = 32'd100; nonce_end = 32'd100; target = '1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle("job_timeout");
    check("pulse_count", pulse_cnt, 1 + 2 * tried);
    if (v.chk_const) begin
      check("const_found", found, v.found);
      check("const_exhausted", exhausted, v.exh);
      check("const_pulses", pulse_cnt, v.pulses);
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t         vt [6];
  vec_t         vs;
  res_t         ra;
  logic [255:0] t7;
  int           bad, k;

  initial begin
    #500000;
    fail_now("global_watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    t7 = d2_of({8{64'h0123456789abcdef}}, 96'hfeedface_cafebabe_00c0ffee, 32'd7);
    vt[0] = '{{16{32'hdeadbeef}}, 96'h1111_2222_3333_4444_5555_6666, 32'd5, 32'd5, '1, 1'b1, 1'b1, 1'b0, 3};
    vt[1] = '{{16{32'h13579bdf}}, 96'habcdef_012345_6789ab_cdef01, 32'd10, 32'd12, '0, 1'b1, 1'b0, 1'b1, 7};
    vt[2] = '{{16{32'h2468ace0}}, 96'h0, 32'hffff_fffe, 32'h0000_0001, '0, 1'b1, 1'b0, 1'b1, 9};
    vt[3] = '{{8{64'h55aa55aa_0f0f0f0f}}, 96'h9, 32'd0, 32'd40, {2'b00, {254{1'b1}}}, 1'b0, 1'b0, 1'b0, 0};
    vt[4] = '{{8{64'h0123456789abcdef}}, 96'hfeedface_cafebabe_00c0ffee, 32'd7, 32'd7, t7, 1'b1, 1'b0, 1'b1, 3};
    vt[5] = '{{8{64'h0123456789abcdef}}, 96'hfeedface_cafebabe_00c0ffee, 32'd7, 32'd7, t7 + 256'd1, 1'b1, 1'b1, 1'b0, 3};

    check("sha_abc", sha_comp(SHA_IV, {24'h616263, 8'h80, 416'b0, 64'd24}),
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    // Reset for two cycles with start held high.
    reset = 1'b1; abort = 1'b0; start = 1'b1;
    hdr_head = '1; hdr_tail = '1; nonce_start = 32'd3; nonce_end = 32'd9; target = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {found, exhausted}, 2'b00);
    check("rst_nonce_out", nonce_out, '0);
    check("rst_hash_out", hash_out, '0);
    check("rst_cf_start", cf_if.cf_start, 1'b0);
    check("rst_cf_block", cf_if.cf_block[255:0] | cf_if.cf_block[511:256], '0);
    check("rst_cf_iv", cf_if.cf_iv, '0);
    repeat (3) @(negedge clk);
    check("rst_start_ignored", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_job(vt[i], 1'b0, 1'b0);

    // Second start mid-job is ignored; start with abort in IDLE is accepted.
    vs = '{{16{32'h0badf00d}}, 96'h7, 32'd20, 32'd23, '0, 1'b1, 1'b0, 1'b1, 9};
    run_job(vs, 1'b1, 1'b0);
    run_job(vt[0], 1'b0, 1'b1);

    // Abort while idle leaves the held result alone.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_found", found, 1'b1);

    // Abort during PASS1 with a slow core: DRAIN until that core result arrives.
    core_lat = 20;
    vs = '{{16{32'h600dcafe}}, 96'h3, 32'd0, 32'd100, '0, 1'b0, 1'b0, 1'b0, 0};
    ra.found = 1'b0; ra.exh = 1'b0; ra.nonce = last_nonce; ra.hash = last_hash;
    exp_nq.push_back(32'd0);
    exp_rq.push_back(ra);
    drive_job(vs, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (model_busy && model_kind == 1) break;
    end
    if (k >= 200) fail_now("pass1_reached");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    bad = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (busy !== 1'b1) bad++;
      if (cf_if.cf_done === 1'b1) break;
    end
    if (k >= 40) fail_now("drain_cf_done");
    check("busy_during_drain", bad, 0);
    @(negedge clk); #1;
    check("busy_after_drain", busy, 1'b0);
    check("flags_after_drain", {found, exhausted}, 2'b00);
    repeat (30) @(negedge clk);
    check("no_start_after_drain", pulse_cnt, 2);
    core_lat = 3;

    // Abort in the CMP cycle.
    vs = '{{16{32'h31415926}}, 96'h5, 32'd0, 32'd5, '0, 1'b0, 1'b0, 1'b0, 0};
    ra.nonce = last_nonce; ra.hash = last_hash;
    exp_nq.push_back(32'd0);
    exp_rq.push_back(ra);
    drive_job(vs, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (cf_if.cf_done === 1'b1 && model_kind == 2) break;
    end
    if (k >= 200) fail_now("pass2_done");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle("cmp_abort_timeout");
    repeat (10) @(negedge clk);
    check("cmp_abort_pulses", pulse_cnt, 3);
    check("cmp_abort_flags", {found, exhausted}, 2'b00);

    // Reset during MID; the stray core result afterwards must be ignored.
    core_lat = 20;
    sb_mute = 1'b1;
    drive_job(vt[3], 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midjob_rst_busy", busy, 1'b0);
    check("midjob_rst_out", {found, exhausted, nonce_out}, '0);
    check("midjob_rst_hash", hash_out, '0);
    check("midjob_rst_cf", {cf_if.cf_start, cf_if.cf_iv}, '0);
    wait_model_idle();
    repeat (10) @(negedge clk);
    check("stray_done_ignored", {busy, pulse_cnt[7:0]}, 9'd1);
    sb_mute = 1'b0;
    core_lat = 3;
    last_nonce = '0; last_hash = '0;

    run_job(vt[1], 1'b0, 1'b0);

    check("nonce_queue_empty", exp_nq.size(), 0);
    check("result_queue_empty", exp_rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
